// File: rtl/mdu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pipe_if
// Brief    : Request/result bundle between the execute stage and mdu_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             op_ready;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, src_a, src_b, flush,
    input  op_ready, done, div_by_zero, hi, lo
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, flush,
    output op_ready, done, div_by_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pipe
// Brief    : HI/LO multiply/divide unit: pipelined multiply, radix-2 divide.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  wire logic clock,
  input  wire logic reset,
  mdu_pipe_if.slave bus
);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_FIX  = 2'd3;

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  localparam int c_CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  logic [1:0]           r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_mulPipe [MUL_STAGES];
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_divisor;
  logic [WIDTH-1:0]     r_dividend;
  logic [WIDTH:0]       r_rem;
  logic                 r_negQuot;
  logic                 r_negRem;
  logic                 r_divZero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_divByZero;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_signed;
  logic [2*WIDTH-1:0]   w_extA;
  logic [2*WIDTH-1:0]   w_extB;
  logic [2*WIDTH-1:0]   w_product;
  logic                 w_negA;
  logic                 w_negB;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [WIDTH:0]       w_remShift;
  logic [WIDTH+1:0]     w_diff;
  logic                 w_qBit;
  logic [WIDTH-1:0]     w_quotFix;
  logic [WIDTH-1:0]     w_remFix;

  assign w_ready  = (r_state == c_IDLE) & ~reset;
  assign w_accept = bus.op_valid & w_ready & ~bus.flush;

  // Odd op codes are the unsigned variants of both MULT and DIV.
  assign w_signed  = ~bus.op_code[0];
  assign w_extA    = w_signed ? {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a} : {{WIDTH{1'b0}}, bus.src_a};
  assign w_extB    = w_signed ? {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b} : {{WIDTH{1'b0}}, bus.src_b};
  assign w_product = w_extA * w_extB;

  assign w_negA = w_signed & bus.src_a[WIDTH-1];
  assign w_negB = w_signed & bus.src_b[WIDTH-1];
  assign w_magA = w_negA ? -bus.src_a : bus.src_a;
  assign w_magB = w_negB ? -bus.src_b : bus.src_b;

  // Restoring step: dividend bits leave r_quot at the top, quotient bits enter at the bottom.
  assign w_remShift = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
  assign w_diff     = {r_rem, r_quot[WIDTH-1]} - {2'b00, r_divisor};
  assign w_qBit     = ~w_diff[WIDTH+1];

  assign w_quotFix = r_negQuot ? -r_quot : r_quot;
  assign w_remFix  = r_negRem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_count     <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_dividend  <= '0;
      r_rem       <= '0;
      r_negQuot   <= 1'b0;
      r_negRem    <= 1'b0;
      r_divZero   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) r_mulPipe[i] <= '0;
    end else begin
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
      if (w_accept) r_mulPipe[0] <= w_product;
      for (int i = 1; i < MUL_STAGES; i++) r_mulPipe[i] <= r_mulPipe[i-1];

      if (bus.flush && (r_state != c_IDLE)) begin
        r_state <= c_IDLE;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (w_accept) begin
              case (bus.op_code)
                c_OP_MULT, c_OP_MULTU: begin
                  r_state <= c_MUL;
                  r_count <= c_CNT_W'(MUL_STAGES - 1);
                end
                c_OP_DIV, c_OP_DIVU: begin
                  r_state    <= c_DIV;
                  r_count    <= c_CNT_W'(WIDTH - 1);
                  r_quot     <= w_magA;
                  r_divisor  <= w_magB;
                  r_dividend <= bus.src_a;
                  r_rem      <= '0;
                  r_negQuot  <= w_negA ^ w_negB;
                  r_negRem   <= w_negA;
                  r_divZero  <= (bus.src_b == '0);
                end
                c_OP_MTHI: r_hi <= bus.src_a;
                c_OP_MTLO: r_lo <= bus.src_a;
                default: ;
              endcase
            end
          end
          c_MUL: begin
            if (r_count == '0) begin
              r_state        <= c_IDLE;
              {r_hi, r_lo}   <= r_mulPipe[MUL_STAGES-1];
              r_done         <= 1'b1;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
          c_DIV: begin
            r_rem  <= w_qBit ? w_diff[WIDTH:0] : w_remShift;
            r_quot <= {r_quot[WIDTH-2:0], w_qBit};
            if (r_count == '0) r_state <= c_FIX;
            else               r_count <= r_count - 1'b1;
          end
          c_FIX: begin
            r_state     <= c_IDLE;
            r_done      <= 1'b1;
            r_divByZero <= r_divZero;
            if (r_divZero) begin
              r_lo <= '1;
              r_hi <= r_dividend;
            end else begin
              r_lo <= w_quotFix;
              r_hi <= w_remFix;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign bus.op_ready    = w_ready;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_divByZero;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule
`default_nettype wire

// File: doc/mdu_pipe.md
# mdu_pipe

Parametrised multiply/divide unit (HI/LO datapath) attached to the execute stage of the pipelined MIPS core. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support, which the current core lacks. Multiplies run through a configurable-depth pipeline. Divides use an iterative radix-2 state machine with a ready/valid handshake, a flush input, and divide-by-zero reporting. The core stalls its decode stage on `op_ready` low and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; legal values ≥ 4.
- `MUL_STAGES`, 2: multiply latency in cycles; legal values ≥ 1.

- `clock`  in  1  rising-edge clock, sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  operation request.
- `op_code`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 accepted as no-op.
- `src_a`  in  WIDTH  rs value: multiplicand / dividend / MTHI-MTLO data.
- `src_b`  in  WIDTH  rt value: multiplier / divisor.
- `flush`  in  1  cancels any in-flight operation.
- `op_ready`  out  1  high when IDLE and able to accept.
- `done`  out  1  one-cycle pulse when HI/LO are updated by a MULT* or DIV* operation.
- `div_by_zero`  out  1  valid only while `done` is high; set when the completed DIV* had `src_b` = 0.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept condition: `op_valid` & `op_ready` & !`flush` at a rising edge. The accepting edge is t0. Operands and op are latched at t0.
- MTHI/MTLO: `hi`/`lo` is written at t0. State stays IDLE, `op_ready` stays high, no `done` pulse.
- MULT/MULTU: the full 2·WIDTH product (signed or unsigned) moves through a `MUL_STAGES` shift pipeline, counted by a down-counter.
  - Transition: IDLE→MUL, then MUL→IDLE on the final stage.
  - On completion: `hi` = product[2W-1:W], `lo` = product[W-1:0].
- DIV/DIVU: operands are converted to magnitudes at t0, and the sign bits are recorded.
  - DIV runs WIDTH restoring shift-subtract iterations, one per cycle.
  - DIV→FIX: FIX applies sign correction and writes `hi`/`lo`, then returns to IDLE.
  - Signed rules: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow: -2^(W-1) / -1 gives `lo` = -2^(W-1), `hi` = 0 (natural wrap, no flag).
  - Divide by zero: iterations still run. Result is `lo` = all ones and `hi` = dividend (unmodified `src_a`). `div_by_zero` = 1 with `done`.
- `op_valid` while `op_ready` is low is ignored. It is not queued; the core is responsible for holding the request.
- `flush`:
  - In any busy state, the next edge returns to IDLE with no `hi`/`lo` write and no `done`.
  - In the same cycle as an `op_valid`, flush wins and the op is not accepted.
  - A `flush` on the same edge a completion would occur suppresses that completion.
- `reset` on any edge (including mid-operation): state IDLE, `hi` = `lo` = 0, `done` = 0, `div_by_zero` = 0, multiply pipeline and counters cleared.
  - `op_ready` = 0 while `reset` is high; `op_ready` = 1 on the first cycle after reset deasserts.
- Arithmetic width:
  - Signed product: sign-extend to 2W before multiplying.
  - Divider: internal remainder register is W+1 bits; all results are truncated to W.

## Timing
- MTHI/MTLO: result visible in the cycle after t0; zero stall.
- MULT*:
  - `op_ready` is low from t0+1 until `done`.
  - `hi`/`lo` update and `done` = 1 in the cycle after edge t0+`MUL_STAGES`.
  - `op_ready` = 1 in that same cycle, so back-to-back accept is possible on that edge.
- DIV*:
  - `hi`/`lo` update and `done` = 1 in the cycle after edge t0+WIDTH+1 (WIDTH iterations plus FIX).
  - `op_ready` rises in the same cycle.
- `done` and `div_by_zero` are registered outputs, each high for exactly one cycle.
- `hi`/`lo` change only at MTHI/MTLO accept, at completion, or at reset.

## Test plan
- MULT with `src_a` = 0xFFFFFFFD, `src_b` = 7 → `done` after 2 edges; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB. MULTU with 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- DIV with -7 / 2 → `done` after 33 edges; `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIVU with 7 / 2 → `lo` = 3, `hi` = 1. `op_valid` pulses during the busy window are ignored.
- DIVU with 100 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000064, `div_by_zero` = 1 for one cycle. DIV with 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0, `div_by_zero` = 0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → both visible immediately, no `done`, `op_ready` never low.
- Preload `hi`/`lo` = 0x11/0x22. Start DIV, assert `flush` at iteration 10 → no `done`, `hi`/`lo` still 0x11/0x22, `op_ready` = 1 next cycle. Repeat with `reset` at iteration 10 → `hi` = `lo` = 0.
- Build with WIDTH = 8, MUL_STAGES = 3. MULT with 0x80 × 0x80 → `hi` = 0x40, `lo` = 0x00 after 3 edges. DIV with 0x81 / 0x03 → `lo` = 0xD6, `hi` = 0xFF after 9 edges.
